// File: rtl/dts_pkg.sv
// Shared FSM encodings and width helpers for the DTS result collector.
// Imported by the collector top and any later host-side blocks.
package dts_pkg;

  localparam logic [1:0] ST_ARB    = 2'd0;
  localparam logic [1:0] ST_ALIGN  = 2'd1;
  localparam logic [1:0] ST_FILL   = 2'd2;
  localparam logic [1:0] ST_RESUME = 2'd3;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int x);
    return (x <= 2) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/result_ram.sv
// Simple dual-port result buffer: one write port, one registered read port.
// Contents are not reset; consumers must qualify reads themselves.
module result_ram #(
  parameter int AW = 4,
  parameter int DW = 20
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [1<<AW];
  logic [DW-1:0] rdata_d;
  logic [DW-1:0] rdata_q;

  always_comb rdata_d = mem_q[raddr];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dts_result_queue.sv
// Round-robin collector: copies the row stream of a done worker into a FIFO of
// result slots, tags it with the worker index and pulses that worker's resume.
module dts_result_queue
  import dts_pkg::*;
#(
  parameter int n            = 3,
  parameter int M            = 19,
  parameter int NUM_WORKERS  = 3,
  parameter int RESULT_SLOTS = 4,
  localparam int R  = $clog2(n),
  localparam int S  = $clog2(RESULT_SLOTS),
  localparam int W  = clog2_min1(NUM_WORKERS),
  localparam int C  = $clog2(RESULT_SLOTS + 1),
  localparam int DW = M + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_WORKERS*DW-1:0] workerRows,
  input  logic [NUM_WORKERS-1:0]    workerDone,
  output logic [NUM_WORKERS-1:0]    workerResume,
  output logic [C-1:0]              resultCount,
  output logic                      resultValid,
  output logic [W-1:0]              resultWorker,
  input  logic [R-1:0]              rdRow,
  output logic [DW-1:0]             rdData,
  input  logic                      pop,
  output logic                      full
);

  logic [1:0]             state_q, state_d;
  logic [W-1:0]           sel_q, sel_d;
  logic [W-1:0]           rr_ptr_q, rr_ptr_d;
  logic [R-1:0]           row_idx_q, row_idx_d;
  logic [DW-1:0]          row_reg_q, row_reg_d;
  logic [S-1:0]           wr_slot_q, wr_slot_d;
  logic [S-1:0]           rd_slot_q, rd_slot_d;
  logic [C-1:0]           count_q, count_d;
  logic [NUM_WORKERS-1:0] pending_q, pending_d;
  logic [W-1:0]           tag_q [RESULT_SLOTS];
  logic [W-1:0]           tag_d [RESULT_SLOTS];
  logic                   rd_ok_q, rd_ok_d;

  logic [DW-1:0]          rows [NUM_WORKERS];
  logic [NUM_WORKERS-1:0] eligible;
  logic [NUM_WORKERS-1:0] resume_vec;
  logic                   commit;
  logic                   do_pop;
  logic                   ram_we;
  logic [S+R-1:0]         ram_waddr;
  logic [S+R-1:0]         ram_raddr;
  logic [DW-1:0]          ram_rdata;

  // First eligible index at or above ptr, otherwise the first one below it.
  function automatic logic [W-1:0] rr_pick(input logic [NUM_WORKERS-1:0] elig,
                                           input logic [W-1:0] ptr);
    logic [W-1:0] g;
    logic         found;
    g     = '0;
    found = 1'b0;
    for (int u = 0; u < NUM_WORKERS; u++) begin
      if (!found && elig[u] && (u >= int'(ptr))) begin
        g     = W'(u);
        found = 1'b1;
      end
    end
    for (int u = 0; u < NUM_WORKERS; u++) begin
      if (!found && elig[u]) begin
        g     = W'(u);
        found = 1'b1;
      end
    end
    return g;
  endfunction

  always_comb begin
    for (int u = 0; u < NUM_WORKERS; u++) rows[u] = workerRows[u*DW +: DW];
  end

  assign full     = (count_q == C'(RESULT_SLOTS));
  assign eligible = workerDone & ~pending_q;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    rr_ptr_d   = rr_ptr_q;
    row_idx_d  = row_idx_q;
    row_reg_d  = row_reg_q;
    wr_slot_d  = wr_slot_q;
    tag_d      = tag_q;
    commit     = 1'b0;
    ram_we     = 1'b0;
    resume_vec = '0;
    case (state_q)
      ST_ARB: begin
        if (!full && (|eligible)) begin
          sel_d   = rr_pick(eligible, rr_ptr_q);
          state_d = ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        row_reg_d = rows[sel_q];
        row_idx_d = '0;
        state_d   = ST_FILL;
      end
      ST_FILL: begin
        // The stream keeps rotating, so n consecutive words cover every row.
        row_reg_d = rows[sel_q];
        ram_we    = 1'b1;
        row_idx_d = row_idx_q + 1'b1;
        if (row_idx_q == R'(n - 1)) begin
          commit            = 1'b1;
          tag_d[wr_slot_q]  = sel_q;
          wr_slot_d         = wr_slot_q + 1'b1;
          state_d           = ST_RESUME;
        end
      end
      default: begin
        for (int u = 0; u < NUM_WORKERS; u++) resume_vec[u] = (sel_q == W'(u));
        rr_ptr_d = (sel_q == W'(NUM_WORKERS - 1)) ? '0 : sel_q + 1'b1;
        state_d  = ST_ARB;
      end
    endcase
  end

  // A done level seen again before it drops must not be captured twice.
  assign pending_d = (pending_q & workerDone) | resume_vec;

  always_comb begin
    do_pop    = pop && (count_q != '0);
    rd_slot_d = rd_slot_q;
    if (do_pop) rd_slot_d = rd_slot_q + 1'b1;
    count_d = count_q;
    case ({commit, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    rd_ok_d = (count_q != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_ARB;
      sel_q     <= '0;
      rr_ptr_q  <= '0;
      row_idx_q <= '0;
      row_reg_q <= '0;
      wr_slot_q <= '0;
      rd_slot_q <= '0;
      count_q   <= '0;
      pending_q <= '0;
      rd_ok_q   <= 1'b0;
      for (int s = 0; s < RESULT_SLOTS; s++) tag_q[s] <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      rr_ptr_q  <= rr_ptr_d;
      row_idx_q <= row_idx_d;
      row_reg_q <= row_reg_d;
      wr_slot_q <= wr_slot_d;
      rd_slot_q <= rd_slot_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      rd_ok_q   <= rd_ok_d;
      for (int s = 0; s < RESULT_SLOTS; s++) tag_q[s] <= tag_d[s];
    end
  end

  assign ram_waddr = {wr_slot_q, row_idx_q};
  assign ram_raddr = {rd_slot_q, rdRow};

  result_ram #(
    .AW(S + R),
    .DW(DW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(row_reg_q),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  assign workerResume = resume_vec;
  assign resultCount  = count_q;
  assign resultValid  = (count_q != '0);
  assign resultWorker = tag_q[rd_slot_q];
  // RAM data is only exposed when the read was issued against a valid head.
  assign rdData       = rd_ok_q ? ram_rdata : '0;

endmodule

// File: tb/tb_dts_result_queue.sv
// Bench for dts_result_queue: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_dts_result_queue;

  localparam int N  = 3;
  localparam int M  = 19;
  localparam int NW = 3;
  localparam int SL = 4;
  localparam int DW = M + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NW*DW-1:0] workerRows = '0;
  logic [NW-1:0]    workerDone = '0;
  logic [NW-1:0]    workerResume;
  logic [2:0]       resultCount;
  logic             resultValid;
  logic [1:0]       resultWorker;
  logic [1:0]       rdRow = '0;
  logic [DW-1:0]    rdData;
  logic             pop = 1'b0;
  logic             full;

  logic [DW-1:0] row_tbl [NW][N] = '{'{20'h00001, 20'h00020, 20'h00300},
                                     '{20'h0000A, 20'h000B0, 20'h00C00},
                                     '{20'h0D000, 20'hE0000, 20'h00F0F}};

  int n_vec = 0;
  int n_err = 0;

  dts_result_queue #(
    .n(N), .M(M), .NUM_WORKERS(NW), .RESULT_SLOTS(SL)
  ) dut (
    .clk(clk), .reset(reset), .workerRows(workerRows), .workerDone(workerDone),
    .workerResume(workerResume), .resultCount(resultCount), .resultValid(resultValid),
    .resultWorker(resultWorker), .rdRow(rdRow), .rdData(rdData), .pop(pop), .full(full)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, failures so far %0d", n_err);
    $fatal(1, "watchdog");
  end

  // Each worker streams its rows continuously, rotating one per cycle.
  initial begin
    int cyc;
    cyc = 0;
    forever begin
      for (int u = 0; u < NW; u++) workerRows[u*DW +: DW] = row_tbl[u][(cyc + u) % N];
      @(posedge clk);
      #1;
      cyc++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_in(input string nm, input logic [DW-1:0] act, input int w);
    bit ok;
    ok = 1'b0;
    n_vec++;
    for (int i = 0; i < N; i++) if (act == row_tbl[w][i]) ok = 1'b1;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, not a row of worker %0d at %0t", nm, act, w, $time);
    end
  endtask

  // Model: FIFO of worker tags plus a capture-progress counter k
  // (0 idle, 1 align, 2..N+1 row copies, N+2 resume pulse).
  int      mk = 0;
  int      msel = 0;
  int      mrr = 0;
  bit [NW-1:0] mpend = '0;
  int      mq[$];
  bit      mrdv = 1'b0;
  int      mrdw = 0;
  int      msz;
  bit      mcommit;
  bit      mgot;
  bit [NW-1:0] mres;

  initial forever begin
    @(negedge clk);
    if (reset) begin
      mk = 0; mq.delete(); mpend = '0; mrr = 0; mrdv = 1'b0;
    end
    chk("count", 32'(resultCount), 32'(mq.size()));
    chk("valid", 32'(resultValid), 32'(mq.size() != 0));
    chk("full", 32'(full), 32'(mq.size() == SL));
    chk("resume", 32'(workerResume), (mk == N + 2) ? (32'd1 << msel) : 32'd0);
    if (mq.size() != 0) chk("head_worker", 32'(resultWorker), 32'(mq[0]));
    if (mrdv) chk_in("rd_data", rdData, mrdw);
    else chk("rd_zero", 32'(rdData), 32'd0);
    if (!reset) begin
      msz     = mq.size();
      mrdv    = (msz != 0);
      if (mrdv) mrdw = mq[0];
      mres    = (mk == N + 2) ? NW'(1 << msel) : '0;
      mcommit = (mk == N + 1);
      if (mk == 0) begin
        mgot = 1'b0;
        if (msz < SL) begin
          for (int d = 0; d < NW; d++) begin
            int u;
            u = (mrr + d) % NW;
            if (!mgot && workerDone[u] && !mpend[u]) begin
              msel = u;
              mgot = 1'b1;
            end
          end
        end
        if (mgot) mk = 1;
      end else if (mk == N + 2) begin
        mrr = (msel + 1) % NW;
        mk  = 0;
      end else begin
        mk++;
      end
      if (pop && msz != 0) void'(mq.pop_front());
      if (mcommit) mq.push_back(msel);
      mpend = (mpend & workerDone) | mres;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    workerDone = '0;
    pop = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  function automatic int onehot_idx(input logic [NW-1:0] v);
    int r;
    r = -1;
    for (int u = 0; u < NW; u++) if (v[u]) r = u;
    return r;
  endfunction

  task automatic wait_resume(input int budget, input int exp_who);
    int who;
    who = -1;
    for (int c = 0; c < budget; c++) begin
      step();
      if (workerResume != '0) begin
        who = onehot_idx(workerResume);
        break;
      end
    end
    chk("resume_worker", 32'(who), 32'(exp_who));
  endtask

  task automatic capture(input int u);
    workerDone = NW'(1 << u);
    wait_resume(8, u);
    workerDone = '0;
    step();
    step();
  endtask

  // Workers that drop done for one cycle shortly after each resume.
  bit [NW-1:0] fw_wait = '0;
  bit [NW-1:0] fw_drop = '0;
  int          grants[$];

  task automatic fair_step();
    int g;
    step();
    for (int u = 0; u < NW; u++) begin
      if (fw_drop[u]) begin
        workerDone[u] = 1'b1;
        fw_drop[u] = 1'b0;
      end else if (fw_wait[u]) begin
        workerDone[u] = 1'b0;
        fw_drop[u] = 1'b1;
        fw_wait[u] = 1'b0;
      end
    end
    if (workerResume != '0) begin
      chk("resume_onehot", 32'($countones(workerResume)), 32'd1);
      g = onehot_idx(workerResume);
      grants.push_back(g);
      fw_wait[g] = 1'b1;
    end
  endtask

  initial begin
    logic [DW-1:0] v [N];
    int hits;
    int exp_order [4] = '{0, 1, 2, 0};

    // Reset values
    #3;
    chk("rst_count", 32'(resultCount), 32'd0);
    chk("rst_resume", 32'(workerResume), 32'd0);
    chk("rst_rddata", 32'(rdData), 32'd0);
    do_reset();

    // Single worker capture
    workerDone = 3'b010;
    repeat (5) step();
    chk("t1_count", 32'(resultCount), 32'd1);
    chk("t1_worker", 32'(resultWorker), 32'd1);
    chk("t1_resume", 32'(workerResume), 32'b010);
    step();
    chk("t1_resume_once", 32'(workerResume), 32'd0);
    workerDone = '0;
    for (int r = 0; r < N; r++) begin
      rdRow = 2'(r);
      step();
      v[r] = rdData;
    end
    chk("t1_row_sum", 32'(v[0]) + 32'(v[1]) + 32'(v[2]), 32'h00CBA);
    chk("t1_rows_distinct", 32'((v[0] != v[1]) && (v[1] != v[2]) && (v[0] != v[2])), 32'd1);
    rdRow = '0;
    pop = 1'b1;
    step();
    pop = 1'b0;
    chk("t1_popped", 32'(resultCount), 32'd0);

    // Fairness, then saturation at full
    do_reset();
    grants.delete();
    fw_wait = '0;
    fw_drop = '0;
    workerDone = 3'b111;
    for (int c = 0; c < 60 && grants.size() < 4; c++) fair_step();
    chk("fair_ngrants", 32'(grants.size()), 32'd4);
    for (int i = 0; i < 4 && i < grants.size(); i++) chk("fair_order", 32'(grants[i]), 32'(exp_order[i]));
    chk("full_count", 32'(resultCount), 32'd4);
    chk("full_flag", 32'(full), 32'd1);
    repeat (15) fair_step();
    chk("full_no_resume", 32'(grants.size()), 32'd4);
    pop = 1'b1;
    fair_step();
    pop = 1'b0;
    chk("full_after_pop", 32'(resultCount), 32'd3);
    repeat (20) fair_step();
    chk("full_one_more", 32'(grants.size()), 32'd5);
    if (grants.size() >= 5) chk("full_fifth_grant", 32'(grants[4]), 32'd1);
    chk("full_again", 32'(full), 32'd1);
    fw_wait = '0;
    fw_drop = '0;
    workerDone = '0;

    // Pop coinciding with commit
    do_reset();
    capture(0);
    capture(2);
    chk("col_pre_count", 32'(resultCount), 32'd2);
    chk("col_pre_head", 32'(resultWorker), 32'd0);
    workerDone = 3'b010;
    repeat (4) step();
    pop = 1'b1;
    step();
    pop = 1'b0;
    chk("col_count", 32'(resultCount), 32'd2);
    chk("col_resume", 32'(workerResume), 32'b010);
    chk("col_head", 32'(resultWorker), 32'd2);
    workerDone = '0;
    pop = 1'b1;
    step();
    pop = 1'b0;
    chk("col_tail_tag", 32'(resultWorker), 32'd1);
    chk("col_tail_count", 32'(resultCount), 32'd1);

    // Stale done held high after resume
    do_reset();
    workerDone = 3'b001;
    wait_resume(8, 0);
    hits = 0;
    repeat (10) begin
      step();
      if (workerResume != '0) hits++;
    end
    chk("stale_no_recapture", 32'(hits), 32'd0);
    chk("stale_count", 32'(resultCount), 32'd1);
    workerDone = 3'b000;
    step();
    workerDone = 3'b001;
    wait_resume(8, 0);
    chk("stale_recapture_count", 32'(resultCount), 32'd2);

    // Reset in the middle of a fill
    do_reset();
    workerDone = 3'b100;
    repeat (3) step();
    reset = 1'b1;
    #1;
    chk("mid_rst_count", 32'(resultCount), 32'd0);
    chk("mid_rst_valid", 32'(resultValid), 32'd0);
    chk("mid_rst_full", 32'(full), 32'd0);
    chk("mid_rst_worker", 32'(resultWorker), 32'd0);
    chk("mid_rst_resume", 32'(workerResume), 32'd0);
    chk("mid_rst_rddata", 32'(rdData), 32'd0);
    step();
    chk("mid_rst_no_resume", 32'(workerResume), 32'd0);
    reset = 1'b0;
    wait_resume(8, 2);
    chk("mid_rst_recount", 32'(resultCount), 32'd1);
    chk("mid_rst_reworker", 32'(resultWorker), 32'd2);
    workerDone = '0;
    for (int r = 0; r < N; r++) begin
      rdRow = 2'(r);
      step();
      v[r] = rdData;
    end
    chk("mid_rst_row_sum", 32'(v[0]) + 32'(v[1]) + 32'(v[2]), 32'hEDF0F);
    rdRow = '0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
